// File: rtl/edge_pkg.sv
// ----------------------------------------------------------------------------
// edge_pkg
//   Shared definitions for the multi-channel edge detector.
//   mode_t encodes which edge direction qualifies an event on a channel:
//     MODE_OFF  (00) never qualifies
//     MODE_RISE (01) rising edges qualify
//     MODE_FALL (10) falling edges qualify
//     MODE_ANY  (11) both directions qualify
// ----------------------------------------------------------------------------
package edge_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_ANY  = 2'b11
    } mode_t;

endpackage

// File: rtl/edge_chan.sv
// ----------------------------------------------------------------------------
// edge_chan
//   One edge-detector channel: synchroniser, optional stability filter,
//   accepted-level register, registered edge pulses, sticky flag and
//   saturating event counter.
//   Optional feature macro: EDGE_FILTER_EN (adds the stability filter).
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   in_lvl    in   asynchronous level input
//   warm_done in   high once the shared warm-up period has elapsed
//   mode      in   event qualification mode (mode_t)
//   evt_clr   in   clears flag and counter (a same-cycle event wins)
//   pos_edge  out  one-cycle pulse on accepted 0->1
//   neg_edge  out  one-cycle pulse on accepted 1->0
//   any_edge  out  pos_edge | neg_edge
//   evt_flag  out  sticky qualified-event flag
//   evt_cnt   out  saturating qualified-event count
// ----------------------------------------------------------------------------
module edge_chan
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
`ifdef EDGE_FILTER_EN
    ,
    parameter int FILT_LEN    = 3
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_lvl,
    input  logic             warm_done,
    input  mode_t            mode,
    input  logic             evt_clr,
    output logic             pos_edge,
    output logic             neg_edge,
    output logic             any_edge,
    output logic             evt_flag,
    output logic [CNT_W-1:0] evt_cnt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   acc_lvl;
    logic                   lvl_q;
    logic                   rise;
    logic                   fall;
    logic                   qual;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_lvl};
        end
    end

`ifdef EDGE_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);

    logic          acc_q;
    logic [FW-1:0] stab_q;

    // The accepted level follows the synchronised level only after it has
    // disagreed for FILT_LEN consecutive cycles; any agreement restarts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= 1'b0;
            stab_q <= '0;
        end else if (sync_q[SYNC_STAGES-1] != acc_q) begin
            if (stab_q == FW'(FILT_LEN - 1)) begin
                acc_q  <= sync_q[SYNC_STAGES-1];
                stab_q <= '0;
            end else begin
                stab_q <= stab_q + 1'b1;
            end
        end else begin
            stab_q <= '0;
        end
    end

    assign acc_lvl = acc_q;
`else
    assign acc_lvl = sync_q[SYNC_STAGES-1];
`endif

    // Edges are compared against the previous accepted level; during warm-up
    // the level register still tracks so a level present at reset is absorbed.
    assign rise = warm_done &  acc_lvl & ~lvl_q;
    assign fall = warm_done & ~acc_lvl &  lvl_q;

    always_comb begin
        qual = 1'b0;
        case (mode)
            MODE_RISE: qual = rise;
            MODE_FALL: qual = fall;
            MODE_ANY:  qual = rise | fall;
            default:   qual = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_q    <= 1'b0;
            pos_edge <= 1'b0;
            neg_edge <= 1'b0;
            any_edge <= 1'b0;
            evt_flag <= 1'b0;
            evt_cnt  <= '0;
        end else begin
            lvl_q    <= acc_lvl;
            pos_edge <= rise;
            neg_edge <= fall;
            any_edge <= rise | fall;

            if (qual) begin
                evt_flag <= 1'b1;
            end else if (evt_clr) begin
                evt_flag <= 1'b0;
            end

            // A clear coinciding with an event restarts the count at one.
            if (evt_clr) begin
                evt_cnt <= CNT_W'(qual);
            end else if (qual && (evt_cnt != '1)) begin
                evt_cnt <= evt_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/edge_detect_multi.sv
// ----------------------------------------------------------------------------
// edge_detect_multi
//   Multi-channel edge detector for asynchronous level inputs. Each channel
//   is an edge_chan instance; this level holds the shared warm-up counter,
//   the port slicing and the registered interrupt.
//   Optional feature macro: EDGE_FILTER_EN (per-channel stability filter,
//   FILT_LEN cycles; FILT_LEN is otherwise ignored).
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   in        in   [CH]        asynchronous level inputs
//   mode      in   [2*CH]      per-channel mode at [2c+1:2c]
//   evt_clr   in   [CH]        per-channel flag/counter clear
//   pos_edge  out  [CH]        rising-edge pulses
//   neg_edge  out  [CH]        falling-edge pulses
//   any_edge  out  [CH]        either-edge pulses
//   evt_flag  out  [CH]        sticky qualified-event flags
//   evt_cnt   out  [CH*CNT_W]  counters, channel c at [c*CNT_W +: CNT_W]
//   irq       out              registered OR of evt_flag
// ----------------------------------------------------------------------------
module edge_detect_multi
    import edge_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int FILT_LEN    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH-1:0]       in,
    input  logic [2*CH-1:0]     mode,
    input  logic [CH-1:0]       evt_clr,
    output logic [CH-1:0]       pos_edge,
    output logic [CH-1:0]       neg_edge,
    output logic [CH-1:0]       any_edge,
    output logic [CH-1:0]       evt_flag,
    output logic [CH*CNT_W-1:0] evt_cnt,
    output logic                irq
);

    if (CH < 1)          begin : g_bad_ch   $error("CH must be >= 1");          end
    if (SYNC_STAGES < 2) begin : g_bad_sync $error("SYNC_STAGES must be >= 2"); end
    if (CNT_W < 1)       begin : g_bad_cnt  $error("CNT_W must be >= 1");       end
    if (FILT_LEN < 1)    begin : g_bad_filt $error("FILT_LEN must be >= 1");    end

    // Edges are suppressed until the synchroniser (and filter) have flushed
    // the post-reset level through to the level register.
`ifdef EDGE_FILTER_EN
    localparam int WARM = SYNC_STAGES + 1 + FILT_LEN;
`else
    localparam int WARM = SYNC_STAGES + 1;
`endif
    localparam int WW = $clog2(WARM + 1);

    logic [WW-1:0] warm_q;
    logic          warm_done;

    assign warm_done = (warm_q == WW'(WARM));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            warm_q <= '0;
        end else if (!warm_done) begin
            warm_q <= warm_q + 1'b1;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
`ifdef EDGE_FILTER_EN
            ,
            .FILT_LEN    (FILT_LEN)
`endif
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_lvl    (in[c]),
            .warm_done (warm_done),
            .mode      (mode_t'(mode[2*c +: 2])),
            .evt_clr   (evt_clr[c]),
            .pos_edge  (pos_edge[c]),
            .neg_edge  (neg_edge[c]),
            .any_edge  (any_edge[c]),
            .evt_flag  (evt_flag[c]),
            .evt_cnt   (evt_cnt[c*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |evt_flag;
        end
    end

endmodule
